// File: rtl/btf_addr_gen_if.sv
// Bundle between a transform controller and the butterfly address sequencer.
// The controller side is master; the sequencer itself uses the slave modport.
interface btf_addr_gen_if #(
   parameter int LOGN = 8
);
   logic            start;
   logic            mode_dit;
   logic            scale;
   logic            stall;
   logic            busy;
   logic            done;
   logic            rd_valid;
   logic [LOGN-1:0] rd_addr_a;
   logic [LOGN-1:0] rd_addr_b;
   logic [LOGN-1:0] tw_addr;
   logic            dif_dit;
   logic            div_by_2;
   logic [1:0]      opcode;
   logic            wr_valid;
   logic [LOGN-1:0] wr_addr_a;
   logic [LOGN-1:0] wr_addr_b;

   modport master (
      output start, mode_dit, scale, stall,
      input  busy, done, rd_valid, rd_addr_a, rd_addr_b, tw_addr, dif_dit,
             div_by_2, opcode, wr_valid, wr_addr_a, wr_addr_b
   );

   modport slave (
      input  start, mode_dit, scale, stall,
      output busy, done, rd_valid, rd_addr_a, rd_addr_b, tw_addr, dif_dit,
             div_by_2, opcode, wr_valid, wr_addr_a, wr_addr_b
   );
endinterface

// File: rtl/btf_addr_gen.sv
// Butterfly address sequencer for an in-place NTT (DIT) / INTT (DIF) over 2^LOGN points.
// Issues read/twiddle addresses one butterfly per cycle and replays them as write addresses.
module btf_addr_gen #(
   parameter int LOGN    = 8,
   parameter int BTF_LAT = 5
) (
   input logic           clk,
   input logic           rst,
   btf_addr_gen_if.slave bus
);
   localparam int SW = $clog2(LOGN);
   localparam int CW = $clog2(BTF_LAT + 1);

   localparam logic [LOGN-1:0] ONE_N      = LOGN'(1);
   localparam logic [LOGN-1:0] N_HALF     = ONE_N << (LOGN - 1);
   localparam logic [SW:0]     STG_ONE_W  = (SW + 1)'(1);
   localparam logic [SW:0]     LOGN_W     = (SW + 1)'(LOGN);
   localparam logic [SW-1:0]   STG_ONE    = SW'(1);
   localparam logic [SW-1:0]   LAST_STAGE = SW'(LOGN - 1);
   localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
   localparam logic [CW-1:0]   LAT_M1     = CW'(BTF_LAT - 1);
   localparam logic [CW-1:0]   LAT_C      = CW'(BTF_LAT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_GAP   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t          state_r, state_nx_s;
   logic [SW-1:0]   stage_r;
   logic [LOGN-1:0] grp_r, idx_r;
   logic [CW-1:0]   cnt_r;
   logic            mode_r, scale_r;

   logic            dit_s, scl_s;
   logic [SW:0]     stage_p1_s, inv_s, shamt_s;
   logic [LOGN-1:0] half_s, groups_s, addr_a_s, addr_b_s, tw_s;
   logic            idx_last_s, grp_last_s, bfly_last_s, stage_last_s;
   logic            issue_s, done_set_s;

   logic            rd_valid_r, div_r, busy_r, done_r;
   logic [LOGN-1:0] rd_a_r, rd_b_r, tw_r;
   logic [BTF_LAT-1:0] vpipe_r;
   logic [LOGN-1:0] apipe_r [BTF_LAT];
   logic [LOGN-1:0] bpipe_r [BTF_LAT];

   // Butterfly geometry for the current (stage, group, index); the start cycle uses the live mode inputs.
   always_comb begin
      if (state_r == ST_IDLE) begin
         dit_s = bus.mode_dit;
         scl_s = bus.scale;
      end else begin
         dit_s = mode_r;
         scl_s = scale_r;
      end
      stage_p1_s = {1'b0, stage_r} + STG_ONE_W;
      inv_s      = LOGN_W - {1'b0, stage_r};
      if (dit_s) begin
         half_s   = N_HALF >> stage_r;
         groups_s = ONE_N << stage_r;
         shamt_s  = inv_s;
         tw_s     = (ONE_N << stage_r) + grp_r;
      end else begin
         half_s   = ONE_N << stage_r;
         groups_s = N_HALF >> stage_r;
         shamt_s  = stage_p1_s;
         // N>>s wraps to 0 at s=0 in LOGN bits, so the modular result is still N-1-g.
         tw_s     = (ONE_N << inv_s) - ONE_N - grp_r;
      end
      addr_a_s     = (grp_r << shamt_s) + idx_r;
      addr_b_s     = addr_a_s + half_s;
      idx_last_s   = (idx_r == (half_s - ONE_N));
      grp_last_s   = (grp_r == (groups_s - ONE_N));
      bfly_last_s  = idx_last_s && grp_last_s;
      stage_last_s = (stage_r == LAST_STAGE);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) state_nx_s = ST_RUN;
            else           state_nx_s = ST_IDLE;
         end
         ST_RUN: begin
            if (issue_s && bfly_last_s) state_nx_s = stage_last_s ? ST_DRAIN : ST_GAP;
            else                        state_nx_s = ST_RUN;
         end
         ST_GAP: begin
            if (cnt_r == LAT_M1) state_nx_s = ST_RUN;
            else                 state_nx_s = ST_GAP;
         end
         ST_DRAIN: begin
            if (cnt_r == LAT_C) state_nx_s = ST_IDLE;
            else                state_nx_s = ST_DRAIN;
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // FSM outputs: the accepting IDLE cycle already issues the first butterfly.
   always_comb begin
      issue_s    = 1'b0;
      done_set_s = 1'b0;
      case (state_r)
         ST_IDLE:  issue_s    = bus.start;
         ST_RUN:   issue_s    = ~bus.stall;
         ST_GAP:   issue_s    = 1'b0;
         ST_DRAIN: done_set_s = (cnt_r == LAT_M1);
         default:  issue_s    = 1'b0;
      endcase
   end

   // Stage/group/index walk (index fastest), phase counter and start-time mode latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_r <= '0;
         grp_r   <= '0;
         idx_r   <= '0;
         cnt_r   <= '0;
         mode_r  <= 1'b0;
         scale_r <= 1'b0;
      end else begin
         if (issue_s) begin
            if (!idx_last_s) begin
               idx_r <= idx_r + ONE_N;
            end else if (!grp_last_s) begin
               idx_r <= '0;
               grp_r <= grp_r + ONE_N;
            end else begin
               idx_r   <= '0;
               grp_r   <= '0;
               stage_r <= stage_last_s ? '0 : stage_r + STG_ONE;
            end
         end
         if (state_nx_s != state_r) begin
            cnt_r <= '0;
         end else if ((state_r == ST_GAP) || (state_r == ST_DRAIN)) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= '0;
         end
         if ((state_r == ST_IDLE) && bus.start) begin
            mode_r  <= bus.mode_dit;
            scale_r <= bus.scale;
         end
      end
   end

   // Registered read-side outputs; addresses hold while nothing issues.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_r <= 1'b0;
         rd_a_r     <= '0;
         rd_b_r     <= '0;
         tw_r       <= '0;
         div_r      <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         rd_valid_r <= issue_s;
         div_r      <= issue_s && stage_last_s && !dit_s && scl_s;
         busy_r     <= (state_nx_s != ST_IDLE);
         done_r     <= done_set_s;
         if (issue_s) begin
            rd_a_r <= addr_a_s;
            rd_b_r <= addr_b_s;
            tw_r   <= tw_s;
         end
      end
   end

   // Write-back delay line matching the butterfly latency; free-running through stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         vpipe_r <= '0;
         for (int k = 0; k < BTF_LAT; k++) begin
            apipe_r[k] <= '0;
            bpipe_r[k] <= '0;
         end
      end else begin
         vpipe_r[0] <= rd_valid_r;
         apipe_r[0] <= rd_a_r;
         bpipe_r[0] <= rd_b_r;
         for (int k = 1; k < BTF_LAT; k++) begin
            vpipe_r[k] <= vpipe_r[k-1];
            apipe_r[k] <= apipe_r[k-1];
            bpipe_r[k] <= bpipe_r[k-1];
         end
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.rd_valid  = rd_valid_r;
   assign bus.rd_addr_a = rd_a_r;
   assign bus.rd_addr_b = rd_b_r;
   assign bus.tw_addr   = tw_r;
   assign bus.dif_dit   = mode_r;
   assign bus.div_by_2  = div_r;
   assign bus.opcode    = 2'd0;
   assign bus.wr_valid  = vpipe_r[BTF_LAT-1];
   assign bus.wr_addr_a = apipe_r[BTF_LAT-1];
   assign bus.wr_addr_b = bpipe_r[BTF_LAT-1];
endmodule

// File: tb/tb_btf_addr_gen.sv
// Directed bench for btf_addr_gen (LOGN=3, BTF_LAT=2): scoreboarded read sequence,
// delayed write-back check, timing of done/busy, stall, restart-while-busy and abort.
module tb_btf_addr_gen;
   localparam int LOGN = 3;
   localparam int LAT  = 2;

   typedef struct packed {
      logic [LOGN-1:0] a;
      logic [LOGN-1:0] b;
      logic [LOGN-1:0] tw;
      logic            div;
      logic            dit;
   } rd_t;

   typedef struct packed {
      logic            v;
      logic [LOGN-1:0] a;
      logic [LOGN-1:0] b;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   btf_addr_gen_if #(.LOGN(LOGN)) bus ();

   btf_addr_gen #(.LOGN(LOGN), .BTF_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int dit_tab [12][3] = '{'{0,4,1}, '{1,5,1}, '{2,6,1}, '{3,7,1},
                           '{0,2,2}, '{1,3,2}, '{4,6,3}, '{5,7,3},
                           '{0,1,4}, '{2,3,5}, '{4,5,6}, '{6,7,7}};
   int dif_tab [12][3] = '{'{0,1,7}, '{2,3,6}, '{4,5,5}, '{6,7,4},
                           '{0,2,3}, '{1,3,3}, '{4,6,2}, '{5,7,2},
                           '{0,4,1}, '{1,5,1}, '{2,6,1}, '{3,7,1}};

   rd_t exp_q [$];
   wr_t hist  [$];
   int  n_asserts = 0;
   int  n_fail    = 0;
   int  cyc       = 0;
   int  done_cyc_g, last_rd_g, n_done_g;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_table(input logic dit, input logic scl);
      rd_t e;
      for (int i = 0; i < 12; i++) begin
         e.a   = LOGN'(dit ? dit_tab[i][0] : dif_tab[i][0]);
         e.b   = LOGN'(dit ? dit_tab[i][1] : dif_tab[i][1]);
         e.tw  = LOGN'(dit ? dit_tab[i][2] : dif_tab[i][2]);
         e.div = !dit && scl && (i >= 8);
         e.dit = dit;
         exp_q.push_back(e);
      end
   endtask

   // One clock: sample after the edge, check the write-back delay and the read scoreboard.
   task automatic step();
      logic r;
      wr_t  w;
      rd_t  e;
      r = rst;
      @(posedge clk);
      #1;
      cyc++;
      if (r) begin
         hist.delete();
         repeat (LAT) hist.push_back('0);
      end
      w = hist.pop_front();
      check("wr_valid", bus.wr_valid, w.v);
      check("wr_addr_a", bus.wr_addr_a, w.a);
      check("wr_addr_b", bus.wr_addr_b, w.b);
      hist.push_back({bus.rd_valid, bus.rd_addr_a, bus.rd_addr_b});
      check("opcode", bus.opcode, 32'd0);
      if (bus.rd_valid === 1'b1) begin
         last_rd_g = cyc;
         if (exp_q.size() == 0) begin
            check("rd_unexpected", bus.rd_valid, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("rd_addr_a", bus.rd_addr_a, e.a);
            check("rd_addr_b", bus.rd_addr_b, e.b);
            check("tw_addr", bus.tw_addr, e.tw);
            check("div_by_2", bus.div_by_2, e.div);
            check("dif_dit", bus.dif_dit, e.dit);
         end
      end else begin
         check("div_idle", bus.div_by_2, 32'd0);
      end
      if (bus.done === 1'b1) begin
         n_done_g++;
         done_cyc_g = cyc;
         check("done_with_wr", bus.wr_valid, 32'd1);
      end
   endtask

   task automatic run_xform(input logic dit, input logic scl, input logic stall0,
                            input int sf, input int sl, input int dup_off, input int exp_done);
      int t0;
      done_cyc_g = -1;
      last_rd_g  = -1;
      n_done_g   = 0;
      push_table(dit, scl);
      bus.mode_dit = dit;
      bus.scale    = scl;
      bus.stall    = stall0;
      bus.start    = 1'b1;
      t0 = cyc;
      step();
      bus.start    = 1'b0;
      bus.stall    = 1'b0;
      bus.mode_dit = ~dit;
      bus.scale    = ~scl;
      check("busy_rise", bus.busy, 32'd1);
      while (done_cyc_g < 0 && (cyc - t0) < 80) begin
         bus.stall = ((cyc - t0) >= sf) && ((cyc - t0) < sf + sl);
         bus.start = ((cyc - t0) == dup_off) || ((cyc - t0) == dup_off + 7);
         step();
         check("busy_run", bus.busy, 32'd1);
      end
      bus.stall = 1'b0;
      bus.start = 1'b0;
      check("done_time", done_cyc_g - t0, exp_done);
      check("last_rd_time", last_rd_g - t0, exp_done - LAT);
      check("sb_empty", exp_q.size(), 32'd0);
      step();
      check("busy_fall", bus.busy, 32'd0);
      repeat (LAT + 2) step();
      check("done_count", n_done_g, 32'd1);
   endtask

   initial begin
      int t0;
      bus.start    = 1'b0;
      bus.mode_dit = 1'b0;
      bus.scale    = 1'b0;
      bus.stall    = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();
      check("rst_busy", bus.busy, 32'd0);
      check("rst_done", bus.done, 32'd0);
      check("rst_rd_valid", bus.rd_valid, 32'd0);
      check("rst_div", bus.div_by_2, 32'd0);
      check("rst_rd_a", bus.rd_addr_a, 32'd0);
      check("rst_rd_b", bus.rd_addr_b, 32'd0);
      check("rst_tw", bus.tw_addr, 32'd0);
      check("rst_dif_dit", bus.dif_dit, 32'd0);

      // Plain DIT, DIF with scaling, DIF unscaled with stall alongside start.
      run_xform(1'b1, 1'b0, 1'b0, -100, 0, -100, 18);
      run_xform(1'b0, 1'b1, 1'b0, -100, 0, -100, 18);
      run_xform(1'b0, 1'b0, 1'b1, -100, 0, -100, 18);

      // Three stall cycles after the second issue delay done by exactly three.
      run_xform(1'b1, 1'b0, 1'b0, 2, 3, -100, 21);

      // Start pulses with flipped mode while busy are ignored.
      run_xform(1'b1, 1'b0, 1'b0, -100, 0, 5, 18);

      // Abort in stage 1, then a clean restart.
      push_table(1'b1, 1'b0);
      bus.mode_dit = 1'b1;
      bus.scale    = 1'b0;
      bus.start    = 1'b1;
      t0 = cyc;
      step();
      bus.start = 1'b0;
      repeat (7) step();
      check("abort_in_stage1", cyc - t0, 32'd8);
      rst = 1'b1;
      step();
      exp_q.delete();
      check("abort_busy", bus.busy, 32'd0);
      check("abort_rd_valid", bus.rd_valid, 32'd0);
      check("abort_done", bus.done, 32'd0);
      rst = 1'b0;
      repeat (LAT + 3) step();
      run_xform(1'b1, 1'b0, 1'b0, -100, 0, -100, 18);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
